// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache tag directory.
package cache_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_INVAL = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOOKUP,
      ST_UPDATE
   } state_e;

   function automatic int clog2_f(input int value);
      int w = 0;
      while ((32'sd1 << w) < value) w = w + 1;
      return w;
   endfunction

   function automatic int tag_w_f(input int addr_w, input int line_bytes, input int num_sets);
      return addr_w - clog2_f(num_sets) - clog2_f(line_bytes);
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: victim way from the current tree bits, next tree bits after a touch.
// Bit value 0 steers the victim to the lower half, 1 to the upper half; touching points every path node away.
module plru_tree
   import cache_pkg::*;
#(
   parameter int WAYS = 8
) (
   input  logic [WAYS-2:0]         state_i,
   input  logic [$clog2(WAYS)-1:0] touch_i,
   output logic [WAYS-2:0]         next_o,
   output logic [$clog2(WAYS)-1:0] victim_o
);

   localparam int WAY_W = clog2_f(WAYS);

   // Padded to WAYS bits so a WAY_W-bit node index covers the whole heap.
   logic [WAYS-1:0]  st_pad;
   logic [WAYS-1:0]  nx_pad;
   logic [WAY_W-1:0] vic_node;
   logic [WAY_W-1:0] tch_node;
   logic             tch_bit;
   logic             unused_pad;

   assign st_pad = {1'b0, state_i};

   always_comb begin
      victim_o = '0;
      vic_node = '0;
      for (int l = 0; l < WAY_W; l++) begin
         victim_o[WAY_W-1-l] = st_pad[vic_node];
         vic_node = (vic_node << 1) + WAY_W'(1) + WAY_W'(st_pad[vic_node]);
      end
   end

   always_comb begin
      nx_pad   = st_pad;
      tch_node = '0;
      tch_bit  = 1'b0;
      for (int l = 0; l < WAY_W; l++) begin
         tch_bit          = touch_i[WAY_W-1-l];
         nx_pad[tch_node] = ~tch_bit;
         tch_node         = (tch_node << 1) + WAY_W'(1) + WAY_W'(tch_bit);
      end
   end

   assign next_o     = nx_pad[WAYS-2:0];
   assign unused_pad = nx_pad[WAYS-1];

endmodule

// File: rtl/cache_tag_dir.sv
// Set-associative tag directory with tree-PLRU replacement, dirty-victim reporting and hit/miss stats.
// Accept -> response two cycles later, ready again one cycle after; ready only in IDLE, no response backpressure.
module cache_tag_dir
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 64,
   parameter int NUM_SETS   = 32768,
   parameter int WAYS       = 8,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_op,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic [$clog2(WAYS)-1:0] rsp_way,
   output logic                    rsp_dirty,
   output logic                    rsp_evict,
   output logic [ADDR_W-1:0]       rsp_evict_addr,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        miss_count
);

   localparam int OFF_W  = clog2_f(LINE_BYTES);
   localparam int SET_W  = clog2_f(NUM_SETS);
   localparam int WAY_W  = clog2_f(WAYS);
   localparam int TAG_W  = tag_w_f(ADDR_W, LINE_BYTES, NUM_SETS);
   localparam int PLRU_W = WAYS - 1;

   // Directory storage carries no reset; the INIT sweep clears valid/dirty/PLRU.
   logic [WAYS-1:0]             valid_mem [NUM_SETS];
   logic [WAYS-1:0]             dirty_mem [NUM_SETS];
   logic [PLRU_W-1:0]           plru_mem  [NUM_SETS];
   logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [NUM_SETS];

   state_e              state_q;
   logic [SET_W-1:0]    idx_q;
   logic                req_ready_q;
   op_e                 op_q;
   logic [TAG_W-1:0]    tag_q;
   logic [SET_W-1:0]    set_q;
   logic                hit_q;
   logic [WAY_W-1:0]    way_q;
   logic [PLRU_W-1:0]   plru_nxt_q;
   logic [CNT_W-1:0]    hit_count_q;
   logic [CNT_W-1:0]    miss_count_q;

   logic                rsp_valid_q;
   logic                rsp_hit_q;
   logic [WAY_W-1:0]    rsp_way_q;
   logic                rsp_dirty_q;
   logic                rsp_evict_q;
   logic [ADDR_W-1:0]   rsp_evict_addr_q;

   logic [WAYS-1:0]             rd_valid;
   logic [WAYS-1:0]             rd_dirty;
   logic [PLRU_W-1:0]           rd_plru;
   logic [WAYS-1:0][TAG_W-1:0]  rd_tags;

   logic                hit_d;
   logic [WAY_W-1:0]    hit_way_d;
   logic                inv_found;
   logic [WAY_W-1:0]    inv_way;
   logic [WAY_W-1:0]    plru_victim;
   logic [WAY_W-1:0]    victim_way;
   logic [WAY_W-1:0]    way_d;
   logic [PLRU_W-1:0]   plru_next;
   logic                is_rw;
   logic                evict_d;
   logic                dirty_d;
   logic [WAY_W-1:0]    rsp_way_d;
   logic [ADDR_W-1:0]   evict_addr_d;
   logic                unused_off;

   assign unused_off = ^req_addr[OFF_W-1:0];

   assign rd_valid = valid_mem[set_q];
   assign rd_dirty = dirty_mem[set_q];
   assign rd_plru  = plru_mem[set_q];
   assign rd_tags  = tag_mem[set_q];

   always_comb begin
      hit_d     = 1'b0;
      hit_way_d = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (rd_valid[w] && (rd_tags[w] == tag_q) && !hit_d) begin
            hit_d     = 1'b1;
            hit_way_d = w[WAY_W-1:0];
         end
         if (!rd_valid[w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = w[WAY_W-1:0];
         end
      end
   end

   // A free way always wins over the PLRU choice.
   assign victim_way = inv_found ? inv_way : plru_victim;
   assign way_d      = hit_d ? hit_way_d : victim_way;

   plru_tree #(
      .WAYS (WAYS)
   ) u_plru (
      .state_i  (rd_plru),
      .touch_i  (way_d),
      .next_o   (plru_next),
      .victim_o (plru_victim)
   );

   assign is_rw        = (op_q == OP_READ) || (op_q == OP_WRITE);
   assign evict_d      = is_rw && !hit_d && rd_valid[victim_way] && rd_dirty[victim_way];
   assign dirty_d      = hit_d ? ((op_q == OP_INVAL) && rd_dirty[hit_way_d]) : evict_d;
   assign rsp_way_d    = (is_rw || hit_d) ? way_d : '0;
   assign evict_addr_d = evict_d ? {rd_tags[victim_way], set_q, {OFF_W{1'b0}}} : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_INIT;
         idx_q            <= '0;
         req_ready_q      <= 1'b0;
         hit_count_q      <= '0;
         miss_count_q     <= '0;
         rsp_valid_q      <= 1'b0;
         rsp_hit_q        <= 1'b0;
         rsp_way_q        <= '0;
         rsp_dirty_q      <= 1'b0;
         rsp_evict_q      <= 1'b0;
         rsp_evict_addr_q <= '0;
      end else begin
         rsp_valid_q      <= 1'b0;
         rsp_hit_q        <= 1'b0;
         rsp_way_q        <= '0;
         rsp_dirty_q      <= 1'b0;
         rsp_evict_q      <= 1'b0;
         rsp_evict_addr_q <= '0;
         case (state_q)
            ST_INIT: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == SET_W'(NUM_SETS - 1)) begin
                  state_q     <= ST_IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  op_q        <= op_e'(req_op);
                  tag_q       <= req_addr[ADDR_W-1 -: TAG_W];
                  set_q       <= req_addr[OFF_W +: SET_W];
                  if (op_e'(req_op) == OP_CLEAR) begin
                     state_q <= ST_INIT;
                     idx_q   <= '0;
                  end else begin
                     state_q <= ST_LOOKUP;
                  end
               end
            end
            ST_LOOKUP: begin
               state_q          <= ST_UPDATE;
               hit_q            <= hit_d;
               way_q            <= way_d;
               plru_nxt_q       <= plru_next;
               rsp_valid_q      <= 1'b1;
               rsp_hit_q        <= hit_d;
               rsp_way_q        <= rsp_way_d;
               rsp_dirty_q      <= dirty_d;
               rsp_evict_q      <= evict_d;
               rsp_evict_addr_q <= evict_addr_d;
               if (is_rw) begin
                  if (hit_d) begin
                     if (~&hit_count_q) hit_count_q <= hit_count_q + 1'b1;
                  end else begin
                     if (~&miss_count_q) miss_count_q <= miss_count_q + 1'b1;
                  end
               end
            end
            ST_UPDATE: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_INIT;
               idx_q   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == ST_INIT) begin
            valid_mem[idx_q] <= '0;
            dirty_mem[idx_q] <= '0;
            plru_mem[idx_q]  <= '0;
         end else if (state_q == ST_UPDATE) begin
            if (op_q == OP_INVAL) begin
               if (hit_q) begin
                  valid_mem[set_q][way_q] <= 1'b0;
                  dirty_mem[set_q][way_q] <= 1'b0;
               end
            end else begin
               plru_mem[set_q] <= plru_nxt_q;
               if (!hit_q) begin
                  valid_mem[set_q][way_q] <= 1'b1;
                  dirty_mem[set_q][way_q] <= (op_q == OP_WRITE);
                  tag_mem[set_q][way_q]   <= tag_q;
               end else if (op_q == OP_WRITE) begin
                  dirty_mem[set_q][way_q] <= 1'b1;
               end
            end
         end
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_hit        = rsp_hit_q;
   assign rsp_way        = rsp_way_q;
   assign rsp_dirty      = rsp_dirty_q;
   assign rsp_evict      = rsp_evict_q;
   assign rsp_evict_addr = rsp_evict_addr_q;
   assign hit_count      = hit_count_q;
   assign miss_count     = miss_count_q;

endmodule
